adt7420_i2c_target: RTL and testbench

I2C target (slave) that emulates the ADT7420 temperature sensor's register interface at address 0x4B. It is the responder for the on-board I2C temperature-read master and lets that master be exercised in simulation and on hardware loopback without the physical sensor. It oversamples `scl` and `sda` on the 100 MHz system clock, decodes START, STOP and repeated START, and ACKs its address. It serves register reads and writes from a small register file fed by a live temperature input.

---
 rtl/adt7420_i2c_target.sv | 178 +++++++++++++++++
 tb/tb_adt7420_i2c_target.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/adt7420_i2c_target.sv
// adt7420_i2c_target: I2C target emulating the ADT7420 register interface; `define ADT7420_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter on scl/sda
module adt7420_i2c_target #(
  parameter logic [6:0] I2C_ADDR = 7'h4B,
  parameter logic [7:0] DEV_ID   = 8'hCB
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl,
  inout  wire         sda,
  input  logic [15:0] temp_in,
  output logic [7:0]  config_reg,
  output logic [7:0]  reg_ptr,
  output logic        busy,
  output logic        rd_done
);
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_WAIT_STOP
  } state_t;
  state_t      r_state, w_state_nx;
  logic [1:0]  r_scl_s, r_sda_s;
  logic        r_scl_d, r_sda_d;
  logic        w_scl_c, w_sda_c;
  logic        w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [3:0]  r_cnt;
  logic [7:0]  r_shift, r_ptr, r_cfg;
  logic [15:0] r_snap;
  logic        r_oe, r_busy, r_rw, r_first;
  logic [7:0]  w_byte, w_rd_data;
  logic        w_match;
  // two-flop synchronizers (preset high like an idle bus) and one-cycle delayed copies for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_scl_s <= 2'b11;
      r_sda_s <= 2'b11;
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_s <= {r_scl_s[0], scl};
      r_sda_s <= {r_sda_s[0], sda};
      r_scl_d <= w_scl_c;
      r_sda_d <= w_sda_c;
    end
`ifdef ADT7420_TARGET_GLITCH_FILTER_EN
  logic [2:0] r_scl_h, r_sda_h;
  logic       r_scl_f, r_sda_f;
  // majority of the last three synchronized samples hides single-cycle glitches
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_scl_h <= 3'b111;
      r_sda_h <= 3'b111;
      r_scl_f <= 1'b1;
      r_sda_f <= 1'b1;
    end else begin
      r_scl_h <= {r_scl_h[1:0], r_scl_s[1]};
      r_sda_h <= {r_sda_h[1:0], r_sda_s[1]};
      r_scl_f <= (r_scl_h[0] & r_scl_h[1]) | (r_scl_h[0] & r_scl_h[2]) | (r_scl_h[1] & r_scl_h[2]);
      r_sda_f <= (r_sda_h[0] & r_sda_h[1]) | (r_sda_h[0] & r_sda_h[2]) | (r_sda_h[1] & r_sda_h[2]);
    end
  assign w_scl_c = r_scl_f;
  assign w_sda_c = r_sda_f;
`else
  assign w_scl_c = r_scl_s[1];
  assign w_sda_c = r_sda_s[1];
`endif
  assign w_scl_rise = w_scl_c & ~r_scl_d;
  assign w_scl_fall = ~w_scl_c & r_scl_d;
  assign w_start    = w_scl_c & r_scl_d & r_sda_d & ~w_sda_c;
  assign w_stop     = w_scl_c & r_scl_d & ~r_sda_d & w_sda_c;
  assign w_byte     = {r_shift[6:0], w_sda_c};
  assign w_match    = r_shift[6:0] == I2C_ADDR;
  assign w_rd_data  = r_ptr == 8'h00 ? r_snap[15:8] :
                      r_ptr == 8'h01 ? r_snap[7:0]  :
                      r_ptr == 8'h03 ? r_cfg        :
                      r_ptr == 8'h0B ? DEV_ID       : 8'h00;
  assign sda        = r_oe ? 1'b0 : 1'bz;
  assign config_reg = r_cfg;
  assign reg_ptr    = r_ptr;
  assign busy       = r_busy;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_state_nx;
  // next state: STOP and START/Sr override any bit-level progress
  always_comb begin
    w_state_nx = r_state;
    if (w_stop) w_state_nx = S_IDLE;
    else if (w_start) w_state_nx = S_ADDR;
    else
      case (r_state)
        S_ADDR:     if (w_scl_rise && r_cnt == 4'd7) w_state_nx = w_match ? S_ADDR_ACK : S_WAIT_STOP;
        S_ADDR_ACK: if (w_scl_fall && r_cnt != 4'd0) w_state_nx = r_rw ? S_RD_BYTE : S_WR_BYTE;
        S_WR_BYTE:  if (w_scl_rise && r_cnt == 4'd7) w_state_nx = S_WR_ACK;
        S_WR_ACK:   if (w_scl_fall && r_cnt != 4'd0) w_state_nx = S_WR_BYTE;
        S_RD_BYTE:  if (w_scl_fall && r_cnt == 4'd8) w_state_nx = S_RD_ACK;
        S_RD_ACK:
          if (w_scl_rise && r_cnt == 4'd0 && w_sda_c) w_state_nx = S_WAIT_STOP;
          else if (w_scl_fall && r_cnt != 4'd0) w_state_nx = S_RD_BYTE;
        default: ;
      endcase
  end
  // outputs: rd_done marks the cycle the master's ACK/NACK is sampled
  always_comb begin
    rd_done = (r_state == S_RD_ACK) && w_scl_rise && (r_cnt == 4'd0) && !w_start && !w_stop;
  end
  // datapath: bit counting, shifting, register file, pointer and sda drive (changed only on scl falls)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_shift <= 8'h00;
      r_ptr   <= 8'h00;
      r_cfg   <= 8'h00;
      r_snap  <= 16'h0000;
      r_oe    <= 1'b0;
      r_busy  <= 1'b0;
      r_rw    <= 1'b0;
      r_first <= 1'b0;
    end else if (w_stop) begin
      r_oe   <= 1'b0;
      r_busy <= 1'b0;
      r_cnt  <= 4'd0;
    end else if (w_start) begin
      r_oe  <= 1'b0;
      r_cnt <= 4'd0;
    end else
      case (r_state)
        S_ADDR:
          if (w_scl_rise) begin
            r_shift <= w_byte;
            r_cnt   <= r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              r_cnt   <= 4'd0;
              r_rw    <= w_sda_c;
              r_first <= 1'b1;
              if (w_match) r_busy <= 1'b1;
              if (w_match && w_sda_c) r_snap <= temp_in;
            end
          end
        S_ADDR_ACK, S_WR_ACK:
          if (w_scl_rise) r_cnt <= 4'd1;
          else if (w_scl_fall && r_cnt == 4'd0) r_oe <= 1'b1;
          else if (w_scl_fall) begin
            r_cnt   <= 4'd0;
            r_shift <= w_rd_data;
            r_oe    <= (r_state == S_ADDR_ACK && r_rw) ? ~w_rd_data[7] : 1'b0;
          end
        S_WR_BYTE:
          if (w_scl_rise) begin
            r_shift <= w_byte;
            r_cnt   <= r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              r_cnt   <= 4'd0;
              r_first <= 1'b0;
              if (r_first) r_ptr <= w_byte;
              else r_ptr <= r_ptr + 8'd1;
              if (!r_first && r_ptr == 8'h03) r_cfg <= w_byte;
            end
          end
        S_RD_BYTE:
          if (w_scl_rise) r_cnt <= r_cnt + 4'd1;
          else if (w_scl_fall && r_cnt == 4'd8) begin
            r_oe  <= 1'b0;
            r_cnt <= 4'd0;
          end else if (w_scl_fall) begin
            r_shift <= {r_shift[6:0], 1'b0};
            r_oe    <= ~r_shift[6];
          end
        S_RD_ACK:
          if (w_scl_rise) begin
            r_ptr <= r_ptr + 8'd1;
            r_cnt <= 4'd1;
          end else if (w_scl_fall && r_cnt != 4'd0) begin
            r_shift <= w_rd_data;
            r_oe    <= ~w_rd_data[7];
            r_cnt   <= 4'd0;
          end
        default: ;
      endcase
endmodule

// File: tb/tb_adt7420_i2c_target.sv
// tb_adt7420_i2c_target: directed I2C master transactions against adt7420_i2c_target
module tb_adt7420_i2c_target;
  localparam int Q = 15;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_low = 1'b0;
  logic [15:0] temp_in = 16'h0000;
  logic [7:0]  config_reg, reg_ptr;
  logic        busy, rd_done;
  wire         sda;
  int          n_vec = 0;
  int          n_err = 0;
  int          n_rd = 0;
  int          n_busy = 0;
  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);
  always #5 clk = ~clk;
  adt7420_i2c_target dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda), .temp_in(temp_in),
    .config_reg(config_reg), .reg_ptr(reg_ptr), .busy(busy), .rd_done(rd_done)
  );
  always @(negedge clk) begin
    if (rd_done) n_rd++;
    if (busy) n_busy++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic start_c;
    m_low = 1'b0; hold(Q);
    scl = 1'b1;   hold(Q);
    m_low = 1'b1; hold(Q);
    scl = 1'b0;   hold(Q);
  endtask
  task automatic stop_c;
    m_low = 1'b1; hold(Q);
    scl = 1'b1;   hold(Q);
    m_low = 1'b0; hold(Q);
  endtask
  task automatic bit_w(input logic b);
    m_low = ~b; hold(Q);
    scl = 1'b1; hold(2 * Q);
    scl = 1'b0; hold(Q);
  endtask
  task automatic bit_r(output logic b);
    m_low = 1'b0; hold(Q);
    scl = 1'b1;   hold(Q);
    b = sda;      hold(Q);
    scl = 1'b0;   hold(Q);
  endtask
  task automatic byte_w(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) bit_w(d[i]);
    bit_r(ack);
  endtask
  task automatic byte_r(input logic nack, output logic [7:0] d);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_r(b);
      d = {d[6:0], b};
    end
    bit_w(nack);
  endtask
  task automatic set_ptr(input logic [7:0] p);
    logic a;
    start_c;
    byte_w(8'h96, a);
    chk("wr_addr_ack", a, 0);
    byte_w(p, a);
    chk("ptr_ack", a, 0);
  endtask
  task automatic read_start;
    logic a;
    start_c;
    byte_w(8'h97, a);
    chk("rd_addr_ack", a, 0);
  endtask
  initial begin
    logic       a, b;
    logic [7:0] d;
    int         rd0, bz0;
    hold(4);
    chk("rst_ptr", reg_ptr, 8'h00);
    chk("rst_cfg", config_reg, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_rd_done", rd_done, 0);
    chk("rst_sda", sda, 1);
    rst_n = 1'b1;
    hold(10);
    temp_in = 16'h0C80;
    rd0 = n_rd;
    set_ptr(8'h00);
    chk("busy_in_xfer", busy, 1);
    read_start;
    byte_r(1'b0, d);
    chk("temp_msb", d, 8'h0C);
    byte_r(1'b1, d);
    chk("temp_lsb", d, 8'h80);
    stop_c;
    chk("rd_done_pulses", n_rd - rd0, 2);
    chk("ptr_after_read", reg_ptr, 8'h02);
    chk("busy_after_stop", busy, 0);
    set_ptr(8'h00);
    read_start;
    byte_r(1'b0, d);
    chk("snap_msb", d, 8'h0C);
    temp_in = 16'h0D00;
    byte_r(1'b1, d);
    chk("snap_lsb", d, 8'h80);
    stop_c;
    set_ptr(8'h03);
    byte_w(8'hA5, a);
    chk("cfg_data_ack", a, 0);
    stop_c;
    chk("cfg_reg", config_reg, 8'hA5);
    chk("ptr_after_cfg_wr", reg_ptr, 8'h04);
    set_ptr(8'h03);
    read_start;
    byte_r(1'b1, d);
    chk("cfg_readback", d, 8'hA5);
    stop_c;
    set_ptr(8'h00);
    byte_w(8'h55, a);
    stop_c;
    set_ptr(8'h00);
    read_start;
    byte_r(1'b0, d);
    chk("ro_msb", d, 8'h0D);
    byte_r(1'b1, d);
    chk("ro_lsb", d, 8'h00);
    stop_c;
    bz0 = n_busy;
    start_c;
    byte_w(8'h94, a);
    chk("mismatch_nack", a, 1);
    byte_w(8'h96, a);
    chk("wait_stop_nack", a, 1);
    chk("mismatch_busy", busy, 0);
    stop_c;
    chk("mismatch_busy_cycles", n_busy - bz0, 0);
    temp_in = 16'h0080;
    set_ptr(8'hFF);
    read_start;
    byte_r(1'b0, d);
    chk("wrap_ff", d, 8'h00);
    byte_r(1'b1, d);
    chk("wrap_00", d, 8'h00);
    stop_c;
    chk("ptr_wrap", reg_ptr, 8'h01);
    temp_in = 16'hF000;
    set_ptr(8'h00);
    read_start;
    d = 8'h00;
    for (int i = 0; i < 4; i++) begin
      bit_r(b);
      d = {d[6:0], b};
    end
    chk("mid_first_nibble", d, 8'h0F);
    m_low = 1'b0; hold(Q);
    scl = 1'b1;   hold(Q);
    chk("bit5_driven", sda, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_sda_release", sda, 1);
    hold(2);
    chk("rst_busy_mid", busy, 0);
    chk("rst_ptr_mid", reg_ptr, 8'h00);
    chk("rst_cfg_mid", config_reg, 8'h00);
    scl = 1'b0;
    hold(Q);
    rst_n = 1'b1;
    hold(Q);
    start_c;
    byte_w(8'h96, a);
    chk("post_rst_ack", a, 0);
    chk("post_rst_busy", busy, 1);
    stop_c;
    chk("post_rst_idle", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
